// File: rtl/piece_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : piece_spawner
//  Description : Next-piece generator. On start, draws a tetromino code from a
//                free-running 8-bit LFSR (retrying while the code is zero),
//                writes the piece into a COLS x ROWS window of grid memory
//                starting at BASE_ADDR, then pulses done. The window is written
//                either completely (empty cells = 0) or only at the four
//                occupied cells. Every write honours mem_ready back-pressure.
//  Revision    : 1.0  initial release
// ============================================================================
module piece_spawner #(
    parameter int         ADDR_W     = 8,
    parameter int         DATA_W     = 8,
    parameter int         BASE_ADDR  = 232,
    parameter int         COLS       = 3,
    parameter int         ROWS       = 4,
    parameter int         FULL_WRITE = 1,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  force_en,
    input  logic [2:0]            force_type,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  we,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     data,
    output logic [2:0]            piece_type,
    output logic [4*ADDR_W-1:0]   cell_addrs
);

    localparam int                c_NCELL = COLS * ROWS;
    localparam int                c_IDX_W = $clog2(c_NCELL);
    localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE_ADDR);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PICK  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [7:0]          r_lfsr;
    logic [c_IDX_W-1:0]  r_idx;
    logic [2:0]          r_piece_type;
    logic [4*ADDR_W-1:0] r_cell_addrs;

    logic [2:0]          w_code;
    logic                w_lfsr_fb;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_occ;
    logic                w_last;

    // Grid addresses of the four occupied cells of a piece, in row-major
    // (ascending offset) order. Each shape table entry is already sorted.
    function automatic logic [4*ADDR_W-1:0] f_shape_addrs(input logic [2:0] code);
        int                  r [4];
        int                  c [4];
        logic [4*ADDR_W-1:0] res;
        res = '0;
        case (code)
            3'd1:    begin r = '{1'b0 ? 0 : 0, 1, 2, 3}; c = '{0, 0, 0, 0}; end // I
            3'd2:    begin r = '{2, 2, 3, 3}; c = '{0, 1, 0, 1}; end            // O
            3'd3:    begin r = '{1, 2, 2, 3}; c = '{1, 0, 1, 1}; end            // T
            3'd4:    begin r = '{2, 2, 3, 3}; c = '{1, 2, 0, 1}; end            // S
            3'd5:    begin r = '{2, 2, 3, 3}; c = '{0, 1, 1, 2}; end            // Z
            3'd6:    begin r = '{1, 2, 3, 3}; c = '{1, 1, 0, 1}; end            // J
            3'd7:    begin r = '{1, 2, 3, 3}; c = '{0, 0, 0, 1}; end            // L
            default: begin r = '{0, 0, 0, 0}; c = '{0, 0, 0, 0}; end
        endcase
        for (int k = 0; k < 4; k++) begin
            res[k*ADDR_W +: ADDR_W] = c_BASE + ADDR_W'(r[k] * COLS + c[k]);
        end
        return res;
    endfunction

    assign w_lfsr_fb = ~(r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]);
    assign w_code    = force_en ? force_type : r_lfsr[2:0];

    // Write sequencing: the full window walks every cell index and decides
    // occupancy by matching the address; sparse mode walks the latched list.
    generate
        if (FULL_WRITE != 0) begin : g_full
            assign w_addr = c_BASE + ADDR_W'(r_idx);
            assign w_occ  = (w_addr == r_cell_addrs[0*ADDR_W +: ADDR_W]) ||
                            (w_addr == r_cell_addrs[1*ADDR_W +: ADDR_W]) ||
                            (w_addr == r_cell_addrs[2*ADDR_W +: ADDR_W]) ||
                            (w_addr == r_cell_addrs[3*ADDR_W +: ADDR_W]);
            assign w_last = (r_idx == c_IDX_W'(c_NCELL - 1));
        end else begin : g_sparse
            assign w_addr = r_cell_addrs[r_idx[1:0]*ADDR_W +: ADDR_W];
            assign w_occ  = 1'b1;
            assign w_last = (r_idx == c_IDX_W'(3));
        end
    endgenerate

    // Free-running LFSR, advances every clock regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // Control FSM: draw a code, latch the piece, walk the writes, signal done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_idx        <= '0;
            r_piece_type <= 3'd0;
            r_cell_addrs <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_PICK;
                    end
                end
                c_PICK: begin
                    // Code zero is the air code: stay and retry with the
                    // already-advanced LFSR next cycle.
                    if (w_code != 3'd0) begin
                        r_piece_type <= w_code;
                        r_cell_addrs <= f_shape_addrs(w_code);
                        r_idx        <= '0;
                        r_state      <= c_WRITE;
                    end
                end
                c_WRITE: begin
                    if (mem_ready) begin
                        if (w_last) begin
                            r_state <= c_DONE;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign busy       = (r_state != c_IDLE);
    assign done       = (r_state == c_DONE);
    assign we         = (r_state == c_WRITE);
    assign addr       = we ? w_addr : '0;
    assign data       = (we && w_occ) ? DATA_W'(r_piece_type) : '0;
    assign piece_type = r_piece_type;
    assign cell_addrs = r_cell_addrs;

endmodule
`default_nettype wire
